// File: rtl/display_pkg.sv
// Shared types and constants for the product display stage.
package display_pkg;

  localparam int unsigned BCD_W = 12;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_e;

  // Active-high segment patterns, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [2:0] DIG_UNITS    = 3'b001;
  localparam logic [2:0] DIG_TENS     = 3'b010;
  localparam logic [2:0] DIG_HUNDREDS = 3'b100;

  // One double-dabble step: correct BCD nibbles >= 5, then shift left
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 2; i < 5; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD nibble to 7-segment decoder with blanking.
module bcd_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode digit; forced blank and non-decimal codes produce dark segments
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/product_display.sv
// Captures the multiplier product on READY rising, converts it to BCD with a
// sequential double-dabble, and scans the result onto a 3-digit display.
module product_display
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 16,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             READY,
  input  logic [7:0]       AQ,
  output logic             BUSY,
  output logic             VALID,
  output logic [BCD_W-1:0] BCD,
  output logic [6:0]       SEG,
  output logic [2:0]       DIGIT_EN
);

  state_e      state_q;
  logic        ready_q;
  logic [19:0] shift_q;
  logic [3:0]  step_q;
  logic        trigger;

  assign trigger = READY & ~ready_q;

  // Conversion FSM: capture, eight dabble steps, then publish the result
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      ready_q <= 1'b1;  // READY already high at reset release must not trigger
      shift_q <= '0;
      step_q  <= '0;
      BUSY    <= 1'b0;
      VALID   <= 1'b0;
      BCD     <= '0;
    end else begin
      ready_q <= READY;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            shift_q <= {12'b0, AQ};
            step_q  <= '0;
            VALID   <= 1'b0;
            BUSY    <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          shift_q <= dabble_step(shift_q);
          step_q  <= step_q + 4'd1;
          if (step_q == 4'd7) state_q <= LOAD;
        end
        LOAD: begin
          BCD     <= shift_q[19:8];
          VALID   <= 1'b1;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [15:0] div_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_next;
  logic [3:0]  nibble;
  logic        blank;
  logic [2:0]  en_next;
  logic [6:0]  seg_next;
  logic        wrap;

  assign wrap = (div_q == 16'(SCAN_DIV - 1));

  // Select the digit that becomes active on the next wrap, with blanking
  always_comb begin
    idx_next = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    nibble   = BCD[3:0];
    blank    = 1'b0;
    en_next  = DIG_UNITS;
    case (idx_next)
      2'd1: begin
        nibble  = BCD[7:4];
        blank   = BLANK_LEADING && (BCD[11:8] == 4'd0) && (BCD[7:4] == 4'd0);
        en_next = DIG_TENS;
      end
      2'd2: begin
        nibble  = BCD[11:8];
        blank   = BLANK_LEADING && (BCD[11:8] == 4'd0);
        en_next = DIG_HUNDREDS;
      end
      default: ;
    endcase
  end

  bcd_seg_decoder u_dec (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_next)
  );

  // Scan divider; outputs refresh only on the wrap edge
  always_ff @(posedge clk) begin
    if (RESET) begin
      div_q    <= '0;
      idx_q    <= '0;
      DIGIT_EN <= DIG_UNITS;
      SEG      <= SEG_0;
    end else if (wrap) begin
      div_q    <= '0;
      idx_q    <= idx_next;
      DIGIT_EN <= en_next;
      SEG      <= seg_next;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_product_display.sv
// Directed bench for product_display with a short scan divider.
module tb_product_display;

  logic        clk = 1'b0;
  logic        RESET;
  logic        READY;
  logic [7:0]  AQ;
  logic        BUSY;
  logic        VALID;
  logic [11:0] BCD;
  logic [6:0]  SEG;
  logic [2:0]  DIGIT_EN;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_display #(
    .SCAN_DIV      (4),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .READY    (READY),
    .AQ       (AQ),
    .BUSY     (BUSY),
    .VALID    (VALID),
    .BCD      (BCD),
    .SEG      (SEG),
    .DIGIT_EN (DIGIT_EN)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and land on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic run_convert(input string tag, input logic [7:0] aq, input logic [11:0] exp_bcd);
    READY = 1'b0;
    tick();
    AQ    = aq;
    READY = 1'b1;
    tick();  // E0
    check_eq({tag, "_busy_e0"}, 32'(BUSY), 32'd1);
    check_eq({tag, "_valid_e0"}, 32'(VALID), 32'd0);
    repeat (8) tick();  // E8
    check_eq({tag, "_busy_e8"}, 32'(BUSY), 32'd1);
    tick();  // E9
    check_eq({tag, "_busy_e9"}, 32'(BUSY), 32'd0);
    check_eq({tag, "_valid_e9"}, 32'(VALID), 32'd1);
    check_eq({tag, "_bcd"}, 32'(BCD), 32'(exp_bcd));
    READY = 1'b0;
  endtask

  // Let the new BCD reach the display, then record one full scan period
  task automatic scan_check(input string tag, input logic [6:0] eu, input logic [6:0] et,
                            input logic [6:0] eh);
    logic [7:0] su, st, sh;
    su = 8'hff;
    st = 8'hff;
    sh = 8'hff;
    repeat (12) tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      case (DIGIT_EN)
        3'b001:  su = {1'b0, SEG};
        3'b010:  st = {1'b0, SEG};
        3'b100:  sh = {1'b0, SEG};
        default: check_eq({tag, "_onehot"}, 32'(DIGIT_EN), 32'd1);
      endcase
    end
    check_eq({tag, "_seg_units"}, 32'(su), 32'(eu));
    check_eq({tag, "_seg_tens"}, 32'(st), 32'(et));
    check_eq({tag, "_seg_hund"}, 32'(sh), 32'(eh));
  endtask

  initial begin
    logic [2:0] exp_en;
    logic [6:0] exp_seg;
    READY = 1'b0;
    AQ    = 8'd0;
    do_reset();

    // Reset state, then one scan period from divider 0
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_valid", 32'(VALID), 32'd0);
    check_eq("rst_bcd", 32'(BCD), 32'd0);
    for (int k = 0; k <= 12; k++) begin
      exp_en  = (k < 4) ? 3'b001 : (k < 8) ? 3'b010 : (k < 12) ? 3'b100 : 3'b001;
      exp_seg = (exp_en == 3'b001) ? 7'h3f : 7'h00;
      check_eq($sformatf("scan0_en_%0d", k), 32'(DIGIT_EN), 32'(exp_en));
      check_eq($sformatf("scan0_seg_%0d", k), 32'(SEG), 32'(exp_seg));
      tick();
    end

    run_convert("p35", 8'd35, 12'h035);
    scan_check("p35", 7'h6d, 7'h4f, 7'h00);
    run_convert("p225", 8'd225, 12'h225);
    scan_check("p225", 7'h6d, 7'h5b, 7'h5b);
    run_convert("p255", 8'd255, 12'h255);
    scan_check("p255", 7'h6d, 7'h6d, 7'h5b);
    run_convert("p100", 8'd100, 12'h100);
    scan_check("p100", 7'h3f, 7'h3f, 7'h06);
    run_convert("p0", 8'd0, 12'h000);
    scan_check("p0", 7'h3f, 7'h00, 7'h00);

    // READY high across reset release must not start a conversion
    READY = 1'b1;
    AQ    = 8'd77;
    do_reset();
    repeat (12) tick();
    check_eq("hold_busy", 32'(BUSY), 32'd0);
    check_eq("hold_valid", 32'(VALID), 32'd0);
    check_eq("hold_bcd", 32'(BCD), 32'd0);
    run_convert("p7", 8'd7, 12'h007);

    // Second rising edge at E4 is ignored
    READY = 1'b0;
    tick();
    AQ    = 8'd35;
    READY = 1'b1;
    tick();  // E0
    READY = 1'b0;
    tick();  // E1
    tick();  // E2
    tick();  // E3
    AQ    = 8'd99;
    READY = 1'b1;
    tick();  // E4: edge lands mid-conversion
    repeat (5) tick();  // E9
    check_eq("ign_busy", 32'(BUSY), 32'd0);
    check_eq("ign_valid", 32'(VALID), 32'd1);
    check_eq("ign_bcd", 32'(BCD), 32'h035);
    repeat (3) tick();
    check_eq("ign_idle", 32'(BUSY), 32'd0);
    READY = 1'b0;

    // Reset at E5 discards the partial conversion
    tick();
    AQ    = 8'd200;
    READY = 1'b1;
    tick();  // E0
    repeat (4) tick();  // E4
    RESET = 1'b1;
    tick();  // E5
    RESET = 1'b0;
    check_eq("mrst_busy", 32'(BUSY), 32'd0);
    check_eq("mrst_valid", 32'(VALID), 32'd0);
    check_eq("mrst_bcd", 32'(BCD), 32'd0);
    check_eq("mrst_en", 32'(DIGIT_EN), 32'd1);
    check_eq("mrst_seg", 32'(SEG), 32'h3f);
    repeat (10) tick();
    check_eq("mrst_stay_valid", 32'(VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
